// File: rtl/data_copy_master.sv
// Word-granular memory copy engine: reads a word from src, writes it to dst,
// repeating for len words over a req/gnt/rvalid data bus, one transaction at a time.
module data_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    output logic [6:0]       data_wdata_intg_o,
    input  logic [31:0]      data_rdata_i,
    input  logic             data_err_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } state_t;

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_next;
    logic [31:0]      cur_off;
    logic [31:0]      next_off;
    logic             unused_addr_bits;

    assign words_next        = words_done_o + LEN_W'(1);
    assign cur_off           = 32'(words_done_o) << 2;
    assign next_off          = 32'(words_next) << 2;
    assign data_be_o         = 4'hF;
    assign data_wdata_intg_o = 7'h0;
    assign unused_addr_bits  = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    // data_wdata_o doubles as the write buffer between the read response and the write request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            words_done_o <= '0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_q        <= {src_addr_i[31:2], 2'b00};
                        dst_q        <= {dst_addr_i[31:2], 2'b00};
                        len_q        <= len_i;
                        words_done_o <= '0;
                        err_o        <= 1'b0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                            state  <= FIN;
                        end else begin
                            busy_o      <= 1'b1;
                            data_req_o  <= 1'b1;
                            data_we_o   <= 1'b0;
                            data_addr_o <= {src_addr_i[31:2], 2'b00};
                            state       <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= FIN;
                        end else begin
                            data_wdata_o <= data_rdata_i;
                            data_req_o   <= 1'b1;
                            data_we_o    <= 1'b1;
                            data_addr_o  <= dst_q + cur_off;
                            state        <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= FIN;
                        end else begin
                            words_done_o <= words_next;
                            if (words_next == len_q) begin
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                state  <= FIN;
                            end else begin
                                data_req_o  <= 1'b1;
                                data_we_o   <= 1'b0;
                                data_addr_o <= src_q + next_off;
                                state       <= RD_REQ;
                            end
                        end
                    end
                end
                FIN: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_copy_master.sv
// Randomized self-checking bench for data_copy_master: a bus responder logs traffic
// and a transaction-list model derived from src/dst/len/error settings predicts it.
module tb_data_copy_master;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [31:0]      src_addr_i;
    logic [31:0]      dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] words_done_o;
    logic             data_req_o;
    logic             data_gnt_i;
    logic             data_rvalid_i;
    logic             data_we_o;
    logic [3:0]       data_be_o;
    logic [31:0]      data_addr_o;
    logic [31:0]      data_wdata_o;
    logic [6:0]       data_wdata_intg_o;
    logic [31:0]      data_rdata_i;
    logic             data_err_i;

    data_copy_master #(.LEN_W(LEN_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .src_addr_i        (src_addr_i),
        .dst_addr_i        (dst_addr_i),
        .len_i             (len_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .words_done_o      (words_done_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_addr_o       (data_addr_o),
        .data_wdata_o      (data_wdata_o),
        .data_wdata_intg_o (data_wdata_intg_o),
        .data_rdata_i      (data_rdata_i),
        .data_err_i        (data_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int          gnt_stall = 0;
    int          err_read_idx = -1;
    int          reads_seen = 0;
    bit          force_stray = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"}, 64'(data_req_o), 64'h0);
        checkOutput({tag, "_we"}, 64'(data_we_o), 64'h0);
        checkOutput({tag, "_be"}, 64'(data_be_o), 64'hF);
        checkOutput({tag, "_addr"}, 64'(data_addr_o), 64'h0);
        checkOutput({tag, "_wdata"}, 64'(data_wdata_o), 64'h0);
        checkOutput({tag, "_intg"}, 64'(data_wdata_intg_o), 64'h0);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'h0);
        checkOutput({tag, "_done"}, 64'(done_o), 64'h0);
        checkOutput({tag, "_err"}, 64'(err_o), 64'h0);
        checkOutput({tag, "_words"}, 64'(words_done_o), 64'h0);
    endtask

    // Responder: grants after gnt_stall idle cycles, answers the cycle after the grant,
    // and checks that a stalled request holds still.
    initial begin
        bit          rsp_pending = 0;
        bit          rsp_err = 0;
        logic [31:0] rsp_data = '0;
        int          stall_cnt = 0;
        txn_t        hold;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = '0;
        forever begin
            @(negedge clk);
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = $urandom;
            if (!rst) begin
                rsp_pending = 0;
                stall_cnt   = 0;
            end else if (force_stray) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = 32'hDEADBEEF;
                force_stray   = 0;
            end else if (rsp_pending) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rsp_data;
                data_err_i    = rsp_err;
                rsp_pending   = 0;
            end else if (data_req_o) begin
                if (stall_cnt == 0) begin
                    hold.we    = data_we_o;
                    hold.addr  = data_addr_o;
                    hold.wdata = data_wdata_o;
                end else begin
                    checkOutput("stall_we", 64'(data_we_o), 64'(hold.we));
                    checkOutput("stall_addr", 64'(data_addr_o), 64'(hold.addr));
                    checkOutput("stall_wdata", 64'(data_wdata_o), 64'(hold.wdata));
                end
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    txn_t t;
                    data_gnt_i = 1'b1;
                    stall_cnt  = 0;
                    t.we    = data_we_o;
                    t.addr  = data_addr_o;
                    t.wdata = data_wdata_o;
                    log_q.push_back(t);
                    checkOutput("be", 64'(data_be_o), 64'hF);
                    if (!data_we_o) begin
                        rsp_err  = (reads_seen == err_read_idx);
                        rsp_data = mem.exists(data_addr_o) ? mem[data_addr_o] : $urandom;
                        reads_seen++;
                    end else begin
                        rsp_err = 0;
                    end
                    rsp_pending = 1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                                 input int stall, input int err_idx, input bit mid_start);
        logic [31:0] src_al;
        logic [31:0] dst_al;
        int          exp_words;
        int          exp_lat;
        int          n;
        bit          hit_err;
        src_al = {src[31:2], 2'b00};
        dst_al = {dst[31:2], 2'b00};
        gnt_stall    = stall;
        err_read_idx = err_idx;
        reads_seen   = 0;
        log_q.delete();
        exp_q.delete();
        hit_err = 0;
        exp_words = len;
        for (int i = 0; i < len; i++) begin
            txn_t t;
            logic [31:0] a;
            a = src_al + 32'(i) * 32'd4;
            mem[a] = $urandom;
            t.we = 1'b0; t.addr = a; t.wdata = '0;
            exp_q.push_back(t);
            if (i == err_idx) begin
                hit_err   = 1;
                exp_words = i;
                break;
            end
            t.we = 1'b1; t.addr = dst_al + 32'(i) * 32'd4; t.wdata = mem[a];
            exp_q.push_back(t);
        end
        exp_lat = hit_err ? (4 + 2 * stall) * err_idx + stall + 3 : (4 + 2 * stall) * len + 1;

        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = LEN_W'(len);
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < 2000) begin
            checkOutput("busy_during", 64'(busy_o), 64'h1);
            src_addr_i = $urandom;
            dst_addr_i = $urandom;
            len_i      = LEN_W'($urandom);
            start_i    = (mid_start && n == 3);
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        if (n >= 2000) begin
            checkOutput("done_timeout", 64'h0, 64'h1);
        end else begin
            checkOutput("done_latency", 64'(n), 64'(exp_lat));
            checkOutput("busy_at_done", 64'(busy_o), 64'h0);
            checkOutput("words_done", 64'(words_done_o), 64'(exp_words));
            checkOutput("err", 64'(err_o), 64'(hit_err));
        end
        @(negedge clk);
        checkOutput("done_single", 64'(done_o), 64'h0);
        checkOutput("busy_after", 64'(busy_o), 64'h0);
        checkOutput("words_hold", 64'(words_done_o), 64'(exp_words));
        checkOutput("err_hold", 64'(err_o), 64'(hit_err));
        checkOutput("txn_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checkOutput("txn_we", 64'(log_q[i].we), 64'(exp_q[i].we));
            checkOutput("txn_addr", 64'(log_q[i].addr), 64'(exp_q[i].addr));
            if (exp_q[i].we)
                checkOutput("txn_wdata", 64'(log_q[i].wdata), 64'(exp_q[i].wdata));
        end
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        start_i    = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        len_i      = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed copies");
        applyStimulus(32'h0000_0100, 32'h0000_0200, 3, 0, -1, 0);
        applyStimulus(32'h0000_1000, 32'h0000_2000, 2, 3, -1, 0);
        applyStimulus(32'h0000_0300, 32'h0000_0400, 4, 0, 1, 0);
        applyStimulus(32'h0000_0500, 32'h0000_0600, 0, 0, -1, 0);
        applyStimulus(32'h0000_0700, 32'h0000_0800, 2, 1, -1, 1);
        applyStimulus(32'hFFFF_FFFC, 32'h0000_1000, 2, 0, -1, 0);
        applyStimulus(32'h0000_0903, 32'h0000_0A02, 2, 2, -1, 0);

        $display("[TB] random copies");
        for (int k = 0; k < 12; k++) begin
            int          len;
            int          stall;
            int          eidx;
            logic [31:0] src;
            len   = $urandom_range(0, 5);
            stall = $urandom_range(0, 3);
            eidx  = -1;
            if (len > 0 && $urandom_range(0, 2) == 0) eidx = $urandom_range(0, len - 1);
            src = $urandom;
            applyStimulus(src, src ^ 32'h8000_0000, len, stall, eidx, k[0]);
        end

        $display("[TB] reset mid-transfer");
        gnt_stall    = 3;
        err_read_idx = -1;
        reads_seen   = 0;
        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = 32'h40;
        dst_addr_i = 32'h80;
        len_i      = LEN_W'(2);
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(data_req_o && data_we_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checkOutput("wr_req_timeout", 64'h0, 64'h1);
        end else begin
            rst = 1'b0;
            @(negedge clk);
            checkResetOutputs("mid_reset");
            rst = 1'b1;
            @(negedge clk);
            force_stray = 1;
            repeat (5) begin
                @(negedge clk);
                checkOutput("stray_req", 64'(data_req_o), 64'h0);
                checkOutput("stray_busy", 64'(busy_o), 64'h0);
                checkOutput("stray_done", 64'(done_o), 64'h0);
                checkOutput("stray_words", 64'(words_done_o), 64'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
